// File: rtl/capture_ctrl.sv
// Capture sequencer for one logic-analyzer channel group: arms, fills the
// pre-trigger ring, counts post-trigger samples, then drives readout.
module capture_ctrl #(
  parameter int unsigned CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [CNT_BITS-1:0] cfg_data,
  input  logic                arm,
  input  logic                abort,
  input  logic                trigger,
  input  logic                sample_valid,
  input  logic                rd_start,
  input  logic                rd_req,
  input  logic                cnt_delay_match,
  input  logic                cnt_read_match,
  output logic                cnt_en,
  output logic                cnt_clr,
  output logic                cnt_wr_en,
  output logic                cnt_reg_sel,
  output logic [CNT_BITS-1:0] cnt_reg_in,
  output logic                mem_we,
  output logic                mem_re,
  output logic                rd_valid,
  output logic                busy,
  output logic                triggered,
  output logic                done,
  output logic                rd_done,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4,
    ST_READ      = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   trig_set;
  logic   trig_clr;

  // State, trigger flag and read-valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_valid <= mem_re;
      if (trig_clr) begin
        triggered <= 1'b0;
      end else if (trig_set) begin
        triggered <= 1'b1;
      end
    end
  end

  assign state = 3'(state_q);
  assign busy  = (state_q == ST_CLEAR) || (state_q == ST_WAIT_TRIG) ||
                 (state_q == ST_POST)  || (state_q == ST_READ);
  assign done  = (state_q == ST_DONE);

  // Next state and combinational strobes; abort overrides everything
  always_comb begin
    state_d     = state_q;
    trig_set    = 1'b0;
    trig_clr    = 1'b0;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_wr_en   = 1'b0;
    cnt_reg_sel = cfg_sel;
    cnt_reg_in  = cfg_data;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    rd_done     = 1'b0;

    if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
      cnt_wr_en = cfg_we;
    end

    if (abort) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d  = ST_CLEAR;
            trig_clr = 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_clr = 1'b1;
          state_d = ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          mem_we = sample_valid;
          if (trigger && sample_valid) begin
            state_d  = ST_POST;
            trig_set = 1'b1;
          end
        end
        ST_POST: begin
          if (cnt_delay_match) begin
            cnt_clr = 1'b1;
            state_d = ST_DONE;
          end else begin
            mem_we = sample_valid;
            cnt_en = sample_valid;
          end
        end
        ST_DONE: begin
          if (arm) begin
            state_d  = ST_CLEAR;
            trig_clr = 1'b1;
          end else if (rd_start) begin
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          if (cnt_read_match) begin
            cnt_clr = 1'b1;
            rd_done = 1'b1;
            state_d = ST_IDLE;
          end else begin
            mem_re = rd_req;
            cnt_en = rd_req;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl with a sample-counter model and
// write/read scoreboards.
module tb_capture_ctrl;
  localparam int unsigned CNT_BITS = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cfg_we, cfg_sel;
  logic [CNT_BITS-1:0] cfg_data;
  logic                arm, abort, trigger, sample_valid, rd_start, rd_req;
  logic                cnt_delay_match, cnt_read_match;
  logic                cnt_en, cnt_clr, cnt_wr_en, cnt_reg_sel;
  logic [CNT_BITS-1:0] cnt_reg_in;
  logic                mem_we, mem_re, rd_valid, busy, triggered, done, rd_done;
  logic [2:0]          state;

  int errors = 0;
  int checks = 0;
  int sample_tag = 0;
  int exp_wr[$];
  int exp_rd[$];
  logic prev_mem_re;

  // Sample counter model
  logic [CNT_BITS-1:0] m_cnt, m_delay, m_read;

  capture_ctrl #(.CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .arm(arm), .abort(abort), .trigger(trigger), .sample_valid(sample_valid),
    .rd_start(rd_start), .rd_req(rd_req), .cnt_delay_match(cnt_delay_match),
    .cnt_read_match(cnt_read_match), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .cnt_wr_en(cnt_wr_en), .cnt_reg_sel(cnt_reg_sel), .cnt_reg_in(cnt_reg_in),
    .mem_we(mem_we), .mem_re(mem_re), .rd_valid(rd_valid), .busy(busy),
    .triggered(triggered), .done(done), .rd_done(rd_done), .state(state)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= '0;
      m_delay <= '0;
      m_read  <= '0;
    end else begin
      if (cnt_clr) m_cnt <= '0;
      else if (cnt_en) m_cnt <= m_cnt + 1'b1;
      if (cnt_wr_en) begin
        if (cnt_reg_sel) m_read <= cnt_reg_in;
        else m_delay <= cnt_reg_in;
      end
    end
  end
  assign cnt_delay_match = (m_cnt == m_delay);
  assign cnt_read_match  = (m_cnt == m_read);

  // Scoreboard monitor: memory writes, reads and rd_valid latency
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mem_re = 1'b0;
    end else begin
      checks++;
      if (rd_valid !== prev_mem_re) begin
        errors++;
        $display("FAIL rd_valid_delay: got %b want %b at %0t", rd_valid, prev_mem_re, $time);
      end
      prev_mem_re = mem_re;
      if (mem_we === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL mem_we_unexpected: tag %0d with no write expected", sample_tag);
        end else begin
          int e;
          e = exp_wr.pop_front();
          if (sample_tag !== e) begin
            errors++;
            $display("FAIL mem_we_tag: got %0d want %0d", sample_tag, e);
          end
        end
      end
      if (rd_valid === 1'b1) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_valid_unexpected: extra read beat at %0t", $time);
        end else begin
          void'(exp_rd.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [CNT_BITS-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (state !== 3'd0 || triggered !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: state=%0d trig=%b rdv=%b want 0 0 0", state, triggered, rd_valid);
    end
    checks++;
    if ({busy, done, cnt_en, cnt_clr, cnt_wr_en, mem_we, mem_re, rd_done} !== 8'h00) begin
      errors++;
      $display("FAIL reset_comb: outputs=%b want 00000000",
               {busy, done, cnt_en, cnt_clr, cnt_wr_en, mem_we, mem_re, rd_done});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cfg_idle();
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'h05;
    @(negedge clk);
    checks++;
    if (cnt_wr_en !== 1'b1 || cnt_reg_sel !== 1'b0 || cnt_reg_in !== 8'h05) begin
      errors++;
      $display("FAIL cfg_idle: we=%b sel=%b data=%h want 1 0 05", cnt_wr_en, cnt_reg_sel, cnt_reg_in);
    end
    @(posedge clk); #1;
    cfg_sel = 1'b1; cfg_data = 8'h03;
    @(negedge clk);
    checks++;
    if (cnt_wr_en !== 1'b1 || cnt_reg_sel !== 1'b1 || cnt_reg_in !== 8'h03) begin
      errors++;
      $display("FAIL cfg_idle_read: we=%b sel=%b data=%h want 1 1 03", cnt_wr_en, cnt_reg_sel, cnt_reg_in);
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Arm, trigger on the 3rd valid sample, valid every other cycle
  task automatic test_capture(input int delay);
    int  post_exp = 0;
    int  nvalid = 0;
    int  post_cycles = 0;
    bit  trig_done = 0;
    bit  done_seen = 0;
    bit  post_clr_ok = 1;
    cfg_write(1'b0, CNT_BITS'(delay));
    arm = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    arm = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || cnt_clr !== 1'b1 || busy !== 1'b1 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL clear_cycle: state=%0d clr=%b busy=%b trig=%b want 1 1 1 0", state, cnt_clr, busy, triggered);
    end
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'h05;
    trigger = 1'b1; sample_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || cnt_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL cfg_blocked: state=%0d wr_en=%b want 2 0", state, cnt_wr_en);
    end
    @(posedge clk); #1;
    cfg_we = 1'b0; trigger = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL trig_no_valid: state=%0d trig=%b want 2 0", state, triggered);
    end
    @(posedge clk); #1;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      sample_tag   = c;
      sample_valid = (c % 2 == 0);
      trigger      = sample_valid && (nvalid == 2) && !trig_done;
      if (sample_valid) begin
        if (!trig_done) begin
          exp_wr.push_back(c);
          if (trigger) trig_done = 1;
        end else if (post_exp < delay) begin
          exp_wr.push_back(c);
          post_exp++;
        end
        nvalid++;
      end
      @(negedge clk);
      if (state === 3'd3) begin
        post_cycles++;
        if (delay == 0 && (cnt_clr !== 1'b1 || mem_we !== 1'b0)) post_clr_ok = 0;
      end
      done_seen = (done === 1'b1);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0; trigger = 1'b0;
    checks++;
    if (!done_seen || state !== 3'd4 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL capture_done d=%0d: seen=%b state=%0d trig=%b want 1 4 1", delay, done_seen, state, triggered);
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL capture_writes d=%0d: %0d writes missing want 0", delay, exp_wr.size());
    end
    if (delay == 0) begin
      checks++;
      if (post_cycles != 1 || !post_clr_ok) begin
        errors++;
        $display("FAIL delay0_post: cycles=%0d clr_ok=%b want 1 1", post_cycles, post_clr_ok);
      end
    end
    exp_wr.delete();
  endtask

  task automatic test_readout(input int depth);
    int  n_re = 0;
    int  n_done = 0;
    bit  back = 0;
    cfg_write(1'b1, CNT_BITS'(depth));
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < depth; i++) exp_rd.push_back(i);
    for (int c = 0; c < 50 && !back; c++) begin
      @(negedge clk);
      if (mem_re === 1'b1) n_re++;
      if (rd_done === 1'b1) n_done++;
      back = (state === 3'd0);
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    tick();
    tick();
    checks++;
    if (n_re != depth || n_done != 1) begin
      errors++;
      $display("FAIL readout_count: mem_re=%0d rd_done=%0d want %0d 1", n_re, n_done, depth);
    end
    checks++;
    if (!back || state !== 3'd0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL readout_end: idle=%b state=%0d pending=%0d want 1 0 0", back, state, exp_rd.size());
    end
    exp_rd.delete();
  endtask

  task automatic test_rearm_from_done();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL rearm_done: state=%0d trig=%b want 1 0", state, triggered);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    abort = 1'b1; trigger = 1'b1; sample_valid = 1'b1; sample_tag = 500;
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || cnt_clr !== 1'b1 || mem_we !== 1'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_cycle: state=%0d clr=%b we=%b en=%b want 2 1 0 0", state, cnt_clr, mem_we, cnt_en);
    end
    @(posedge clk); #1;
    abort = 1'b0; trigger = 1'b0; sample_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: state=%0d trig=%b want 0 0", state, triggered);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    cfg_write(1'b0, 8'd10);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    trigger = 1'b1; sample_valid = 1'b1; sample_tag = 99;
    exp_wr.push_back(99);
    tick();
    trigger = 1'b0; sample_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL post_entry: state=%0d trig=%b want 3 1", state, triggered);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || triggered !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d trig=%b busy=%b want 0 0 0", state, triggered, busy);
    end
    exp_wr.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    cfg_we = 0; cfg_sel = 0; cfg_data = '0; arm = 0; abort = 0; trigger = 0;
    sample_valid = 0; rd_start = 0; rd_req = 0;
    test_reset();
    test_cfg_idle();
    test_capture(4);
    test_readout(3);
    test_capture(0);
    test_rearm_from_done();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
